zone_water_scheduler: RTL and testbench
=======================================

Name: zone_water_scheduler

Overview:
- Shares one pump/main-valve supply among N irrigation zones. Each zone's watering controller drives its water_toggle request into this block.
- The block grants exactly one zone at a time using round-robin arbitration.
- It caps each grant at a programmable on-time and inserts a programmable pump-settle gap between grants.
- It sits between the per-zone watering FSMs and the valve/pump drivers.

Parameters:
- N_ZONES, 4, number of requesting zones (2..8)
- CNT_W, 8, width of the on-time and settle counters and their config inputs
- ZW, $clog2(N_ZONES), width of the zone index

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable; 0 blocks new grants and aborts any open grant
- zone_req  in  N_ZONES  per-zone water request (level), driven by the zone FSMs' water_toggle
- max_on_time  in  CNT_W  maximum clk cycles per grant; 0 = unlimited
- settle_time  in  CNT_W  idle cycles between grants; 0 = no gap
- valve_en  out  N_ZONES  one-hot (or zero) zone valve drive
- pump_on  out  1  pump drive; high only while a valve is open
- active_zone  out  ZW  index of the granted zone; holds the last value when idle
- busy  out  1  high in OPEN or GAP
- zone_done  out  N_ZONES  one-cycle pulse when a grant ends normally (request drop or timeout)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; valve_en=0, pump_on=0, active_zone=0, busy=0, zone_done=0; rr_ptr=0, on_cnt=0, gap_cnt=0. Reset mid-grant closes the valve immediately.
- All logic is registered on posedge clk. Outputs come directly from flops.
- States: IDLE, OPEN, GAP (2-bit encoding).
- IDLE:
  - If enable=1 and zone_req≠0: winner = first set bit searching upward from rr_ptr, wrapping at N_ZONES-1→0.
  - Next cycle: state=OPEN, active_zone=winner, valve_en=1<<winner, pump_on=1, busy=1, on_cnt=1.
  - Latency: request sampled at edge t → valve open after edge t+1.
- OPEN:
  - on_cnt increments each cycle and saturates at all-ones.
  - The grant ends when zone_req[active_zone]=0, or when max_on_time≠0 and on_cnt==max_on_time.
  - With the request held, the valve is open exactly max_on_time cycles.
- Normal grant end:
  - Next cycle: valve_en=0, pump_on=0, zone_done[active_zone]=1 for that single cycle, rr_ptr=(active_zone+1) mod N_ZONES.
  - If settle_time≠0: state=GAP, gap_cnt=1. Otherwise state=IDLE.
- Simultaneous request drop and timeout: one grant end, one zone_done pulse.
- enable=0 in OPEN: same close and rr_ptr update as a normal end, but no zone_done pulse (abort). Go to GAP if settle_time≠0, else IDLE.
- GAP:
  - All valves off, busy=1.
  - gap_cnt increments; when gap_cnt==settle_time, state=IDLE.
  - Gap is exactly settle_time cycles.
  - Requests are ignored during GAP.
- Fairness:
  - A timed-out zone that is still requesting stays eligible.
  - Because rr_ptr advances past it, any other requesting zone wins first.
  - A lone requester is regranted after the gap.
- max_on_time and settle_time are sampled live. Changing them mid-grant takes effect on the next compare.
- If max_on_time is lowered below the current on_cnt, the grant ends on the next cycle.
- Invariants: valve_en is one-hot or zero; pump_on == |valve_en; zone_done is at most one-hot.

Decomposition:
- Package irr_pkg holds:
  - state encodings SCH_IDLE, SCH_OPEN, SCH_GAP (extend the existing STANDBY/STANDBY_DAWN/WATERING set there);
  - default N_ZONES and CNT_W.
- One combinational sub-module, rr_pick: inputs req[N], ptr[ZW]; outputs any and idx[ZW]; rotate-priority search.

Test Plan:
1. Single request: zone_req=0001, max_on_time=5, settle_time=3, held high → valve_en=0001 and pump_on for exactly 5 cycles, starting one cycle after the request. Then zone_done[0] pulses, 3 idle cycles, then regrant to zone 0.
2. Round-robin: zone_req=1011 held, max_on_time=4, settle_time=0 → grant order 0,1,3,0,1,3. Each grant lasts 4 cycles and valve_en is never multi-hot.
3. Early drop: zone 2 granted, zone_req[2] falls at on_cnt=2 with max_on_time=10 → valve closes the next cycle, zone_done[2] pulses once, rr_ptr=3.
4. Abort: enable goes 0 mid-grant on zone 1 → valve_en=0 next cycle, no zone_done pulse. No new grants while enable=0; grants resume from zone 2 after enable returns.
5. Unlimited and reset: max_on_time=0, zone 3 held for 300 cycles → valve stays open, on_cnt saturates at 255 without closing. Assert rst_n=0 asynchronously mid-cycle → valve_en, pump_on and busy drop immediately, without waiting for a clk edge.
6. Coincident end: timeout cycle equals the request-drop cycle (max_on_time=3, req low at on_cnt=3) → exactly one zone_done pulse and a single GAP entry.

Source files
------------

// File: rtl/irr_pkg.sv
// Shared irrigation types: per-zone controller states plus the pump scheduler
// states and block defaults.
package irr_pkg;

  typedef enum logic [1:0] {
    STANDBY      = 2'd0,
    STANDBY_DAWN = 2'd1,
    WATERING     = 2'd2
  } zone_state_e;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_OPEN = 2'd1,
    SCH_GAP  = 2'd2
  } sch_state_e;

  localparam int N_ZONES_DEF = 4;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int ZW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [ZW-1:0] ptr,
  output logic          any,
  output logic [ZW-1:0] idx
);

  int k;

  // Scan from the farthest offset down so the closest hit to ptr lands last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        any = 1'b1;
        idx = ZW'(k);
      end
    end
  end

endmodule

// File: rtl/zone_water_scheduler.sv
// Round-robin pump/main-valve scheduler: one zone at a time, capped on-time,
// optional pump-settle gap between grants.
module zone_water_scheduler
  import irr_pkg::*;
#(
  parameter int N_ZONES = N_ZONES_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ZW      = $clog2(N_ZONES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_ZONES-1:0] zone_req,
  input  logic [CNT_W-1:0]   max_on_time,
  input  logic [CNT_W-1:0]   settle_time,
  output logic [N_ZONES-1:0] valve_en,
  output logic               pump_on,
  output logic [ZW-1:0]      active_zone,
  output logic               busy,
  output logic [N_ZONES-1:0] zone_done
);

  sch_state_e         state, state_nxt;
  logic [ZW-1:0]      rr_ptr, rr_ptr_nxt, zone_nxt, ptr_after;
  logic [CNT_W-1:0]   on_cnt, on_cnt_nxt, gap_cnt, gap_cnt_nxt;
  logic [N_ZONES-1:0] valve_nxt, done_nxt;
  logic               pump_nxt, busy_nxt;
  logic               pick_any, timeout, grant_end;
  logic [ZW-1:0]      pick_idx;

  rr_pick #(.N(N_ZONES), .ZW(ZW)) u_pick (
    .req (zone_req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign ptr_after = (active_zone == ZW'(N_ZONES - 1)) ? '0 : active_zone + ZW'(1);
  // >= so a max_on_time lowered under the running count still closes promptly.
  assign timeout   = (max_on_time != '0) && (on_cnt >= max_on_time);
  assign grant_end = !zone_req[active_zone] || timeout;

  always_comb begin
    state_nxt   = state;
    zone_nxt    = active_zone;
    valve_nxt   = valve_en;
    pump_nxt    = pump_on;
    busy_nxt    = busy;
    done_nxt    = '0;
    rr_ptr_nxt  = rr_ptr;
    on_cnt_nxt  = on_cnt;
    gap_cnt_nxt = gap_cnt;
    case (state)
      SCH_IDLE: begin
        if (enable && pick_any) begin
          state_nxt  = SCH_OPEN;
          zone_nxt   = pick_idx;
          valve_nxt  = N_ZONES'(1) << pick_idx;
          pump_nxt   = 1'b1;
          busy_nxt   = 1'b1;
          on_cnt_nxt = CNT_W'(1);
        end
      end
      SCH_OPEN: begin
        if (on_cnt != '1) on_cnt_nxt = on_cnt + CNT_W'(1);
        if (!enable || grant_end) begin
          valve_nxt  = '0;
          pump_nxt   = 1'b0;
          rr_ptr_nxt = ptr_after;
          // An abort (enable low) closes silently.
          if (enable) done_nxt = N_ZONES'(1) << active_zone;
          if (settle_time != '0) begin
            state_nxt   = SCH_GAP;
            gap_cnt_nxt = CNT_W'(1);
          end else begin
            state_nxt = SCH_IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      SCH_GAP: begin
        if (gap_cnt >= settle_time) begin
          state_nxt = SCH_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          gap_cnt_nxt = gap_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = SCH_IDLE;
        valve_nxt = '0;
        pump_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCH_IDLE;
      active_zone <= '0;
      valve_en    <= '0;
      pump_on     <= 1'b0;
      busy        <= 1'b0;
      zone_done   <= '0;
      rr_ptr      <= '0;
      on_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      active_zone <= zone_nxt;
      valve_en    <= valve_nxt;
      pump_on     <= pump_nxt;
      busy        <= busy_nxt;
      zone_done   <= done_nxt;
      rr_ptr      <= rr_ptr_nxt;
      on_cnt      <= on_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_zone_water_scheduler.sv
// Directed bench for zone_water_scheduler: checks at negedge, drives at negedge.
module tb_zone_water_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] zone_req = '0;
  logic [W-1:0] max_on_time = '0;
  logic [W-1:0] settle_time = '0;
  logic [N-1:0] valve_en, zone_done;
  logic         pump_on, busy;
  logic [1:0]   active_zone;

  int tests = 0;
  int fails = 0;

  zone_water_scheduler #(.N_ZONES(N), .CNT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .zone_req    (zone_req),
    .max_on_time (max_on_time),
    .settle_time (settle_time),
    .valve_en    (valve_en),
    .pump_on     (pump_on),
    .active_zone (active_zone),
    .busy        (busy),
    .zone_done   (zone_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    zone_req = '0;
    enable   = 1'b1;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int ord[3];
    int z;
    int pulses;
    int busy_cyc;
    ord[0] = 0; ord[1] = 1; ord[2] = 3;

    // Reset state
    do_reset();
    chk("rst_valve", valve_en, 0);
    chk("rst_pump", pump_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zone", active_zone, 0);
    chk("rst_done", zone_done, 0);

    // 1: single request, 5-cycle grant, 3-cycle settle, regrant
    max_on_time = 8'd5; settle_time = 8'd3; zone_req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_valve", valve_en, 4'b0001);
      chk("t1_pump", pump_on, 1);
    end
    step();
    chk("t1_close", valve_en, 0);
    chk("t1_done", zone_done, 4'b0001);
    chk("t1_busy_gap0", busy, 1);
    step();
    chk("t1_done_once", zone_done, 0);
    chk("t1_busy_gap1", busy, 1);
    step();
    chk("t1_busy_gap2", busy, 1);
    chk("t1_gap_valve", valve_en, 0);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_valve", valve_en, 0);
    step();
    chk("t1_regrant", valve_en, 4'b0001);
    chk("t1_regrant_zone", active_zone, 0);

    // 2: round-robin 0,1,3 with 4-cycle grants, no settle
    do_reset();
    max_on_time = 8'd4; settle_time = 8'd0; zone_req = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      z = ord[g % 3];
      for (int c = 0; c < 5; c++) begin
        step();
        if (c < 4) begin
          chk("t2_valve", valve_en, 32'(1) << z);
          if (c == 0) chk("t2_zone", active_zone, z);
        end else begin
          chk("t2_close", valve_en, 0);
          chk("t2_done", zone_done, 32'(1) << z);
        end
      end
    end

    // 3: early drop on zone 2 at on_cnt=2
    do_reset();
    max_on_time = 8'd10; settle_time = 8'd0; zone_req = 4'b0100;
    step();
    chk("t3_grant", valve_en, 4'b0100);
    step();
    chk("t3_hold", valve_en, 4'b0100);
    zone_req = 4'b0000;
    step();
    chk("t3_close", valve_en, 0);
    chk("t3_done", zone_done, 4'b0100);
    zone_req = 4'b1111;
    step();
    chk("t3_ptr_zone", active_zone, 3);
    chk("t3_ptr_valve", valve_en, 4'b1000);
    chk("t3_done_once", zone_done, 0);

    // 4: abort mid-grant on zone 1, resume from zone 2
    do_reset();
    max_on_time = 8'd0; settle_time = 8'd0; zone_req = 4'b0010;
    step(2);
    chk("t4_open", valve_en, 4'b0010);
    enable = 1'b0;
    step();
    chk("t4_abort_valve", valve_en, 0);
    chk("t4_abort_nodone", zone_done, 0);
    zone_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_blocked", valve_en, 0);
      chk("t4_blocked_done", zone_done, 0);
    end
    enable = 1'b1;
    step();
    chk("t4_resume_zone", active_zone, 2);
    chk("t4_resume_valve", valve_en, 4'b0100);

    // 5: unlimited on-time, counter saturates, async reset closes valve
    do_reset();
    max_on_time = 8'd0; settle_time = 8'd0; zone_req = 4'b1000;
    step(300);
    chk("t5_open", valve_en, 4'b1000);
    chk("t5_sat", dut.on_cnt, 8'hFF);
    chk("t5_nodone", zone_done, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valve", valve_en, 0);
    chk("t5_async_pump", pump_on, 0);
    chk("t5_async_busy", busy, 0);
    step();
    rst_n = 1'b1;

    // 6: timeout coincides with request drop
    do_reset();
    max_on_time = 8'd3; settle_time = 8'd2; zone_req = 4'b0001;
    step(3);
    chk("t6_open", valve_en, 4'b0001);
    zone_req = 4'b0000;
    pulses = 0;
    busy_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (zone_done != 0) pulses++;
      if (busy) busy_cyc++;
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_gap_cycles", busy_cyc, 2);
    chk("t6_final_valve", valve_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
